// File: rtl/period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : period_meter                                                  |
// | Description: Health monitor for a slow square-wave timing tick. Brings the |
// |              asynchronous input into the clk_in domain and detects its     |
// |              rising edges. It counts clk_in cycles between edges and       |
// |              reports each full period with a one-cycle strobe. The locked  |
// |              flag follows a run of near-nominal periods, and the timeout   |
// |              flag is raised when edges stop arriving.                      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   CNT_W          width of the period counter and of period_out             |
// |   EXPECTED       nominal period in clk_in cycles                           |
// |   TOL            allowed |period - EXPECTED| for an in-range period        |
// |   LOCK_COUNT     consecutive in-range periods needed to assert locked      |
// |   TIMEOUT_CYCLES cycles without a rising edge before timeout (< 2**CNT_W)  |
// | Ports                                                                      |
// |   clk_in        in   1      system clock                                   |
// |   rst_n         in   1      synchronous reset, active-low                  |
// |   sig_in        in   1      asynchronous signal to measure                 |
// |   period_out    out  CNT_W  last measured period, in cycles                |
// |   period_valid  out  1      one-cycle pulse when period_out updates        |
// |   locked        out  1      LOCK_COUNT consecutive in-range periods seen   |
// |   timeout       out  1      no rising edge for TIMEOUT_CYCLES              |
// | Optional feature (macro PERIOD_METER_MINMAX_EN)                            |
// |   stats_clr     in   1      clears the min/max statistics                  |
// |   period_min    out  CNT_W  smallest reported period since clear           |
// |   period_max    out  CNT_W  largest reported period since clear            |
// +----------------------------------------------------------------------------+
module period_meter #(
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned EXPECTED       = 20000,
  parameter int unsigned TOL            = 100,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
`ifdef PERIOD_METER_MINMAX_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
`endif
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The lower bound clamps at zero so that a tolerance wider than the nominal
  // period cannot wrap around into a huge unsigned value.
  localparam int unsigned LO_BOUND = (TOL > EXPECTED) ? 0 : (EXPECTED - TOL);
  localparam int unsigned HI_BOUND = EXPECTED + TOL;
  localparam int unsigned LOCK_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_COUNT);
  localparam logic [LOCK_W-1:0] LOCK_ONE    = LOCK_W'(1);

  // Range bounds are widened to 64 bits so the compare never truncates,
  // whatever CNT_W is.
  localparam logic [63:0] LO_BOUND_X = 64'(LO_BOUND);
  localparam logic [63:0] HI_BOUND_X = 64'(HI_BOUND);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              prev_q;
  logic [CNT_W-1:0]  count_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_d;

  logic        rise;
  logic        count_sat;
  logic [63:0] count_x;
  logic        in_range;

  // --------------------------------------------------------------------------
  // Edge detection and range check
  // --------------------------------------------------------------------------
  // The synchroniser and the previous-sample register reset high. A line that
  // is already high when reset is released therefore produces no edge; a real
  // 0->1 transition must be observed first.
  assign rise      = sync2_q & ~prev_q;
  assign count_sat = (count_q == TIMEOUT_VAL);
  assign count_x   = 64'(count_q);
  assign in_range  = (count_x >= LO_BOUND_X) && (count_x <= HI_BOUND_X);

  // Next lock-run length if the period that is ending now gets reported.
  always_comb begin
    lock_cnt_d = '0;
    if (in_range) begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : (lock_cnt_q + LOCK_ONE);
    end
  end

  // --------------------------------------------------------------------------
  // Synchroniser, period counter and control FSM (registered outputs)
  // --------------------------------------------------------------------------
  // The synchroniser adds the same 3-cycle delay to every edge, so measured
  // periods are not biased. The counter restarts at 1 on the cycle a rise is
  // acted on. As a result, rises N cycles apart are reported as exactly N.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= S_IDLE;
      count_q      <= '0;
      lock_cnt_q   <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sync1_q      <= sig_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      period_valid <= 1'b0;

      // The free-running count saturates, so it can double as the timeout
      // detector without wrapping.
      if (!count_sat) begin
        count_q <= count_q + CNT_ONE;
      end

      case (state_q)
        S_IDLE: begin
          // The first edge after reset only opens a measurement window.
          if (rise) begin
            state_q <= S_MEASURE;
            count_q <= CNT_ONE;
          end else if (count_sat) begin
            state_q    <= S_TIMEOUT;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            lock_cnt_q <= '0;
          end
        end

        S_MEASURE: begin
          // A rise on the same cycle the count saturates still closes a
          // valid period, so the rise is checked first.
          if (rise) begin
            period_out   <= count_q;
            period_valid <= 1'b1;
            count_q      <= CNT_ONE;
            lock_cnt_q   <= lock_cnt_d;
            locked       <= (lock_cnt_d == LOCK_MAX);
          end else if (count_sat) begin
            state_q    <= S_TIMEOUT;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            lock_cnt_q <= '0;
          end
        end

        S_TIMEOUT: begin
          // The gap that ended here has no known length, so nothing is
          // reported; measuring simply restarts from this edge.
          if (rise) begin
            state_q <= S_MEASURE;
            count_q <= CNT_ONE;
            timeout <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_MINMAX_EN
  // --------------------------------------------------------------------------
  // Min/max statistics over reported periods
  // --------------------------------------------------------------------------
  // The update runs off the registered period_valid/period_out pair, so it
  // lands one cycle after the strobe. A clear on the same cycle takes
  // priority over the update.
  always_ff @(posedge clk_in) begin
    if (!rst_n || stats_clr) begin
      period_min <= '1;
      period_max <= '0;
    end else if (period_valid) begin
      if (period_out < period_min) begin
        period_min <= period_out;
      end
      if (period_out > period_max) begin
        period_max <= period_out;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_period_meter                                               |
// | Description: Self-checking bench for period_meter. Drives trains of rising |
// |              edges with chosen gaps and compares the reported periods and  |
// |              lock flags against a gap-level reference model.               |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_period_meter;

  localparam int CNT_W   = 8;
  localparam int EXP     = 20;
  localparam int TOL     = 1;
  localparam int LOCKN   = 3;
  localparam int TO      = 40;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig   = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout;
`ifdef PERIOD_METER_MINMAX_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
`endif

  int   checks = 0;
  int   errors = 0;
  int   gaps_q[$];
  int   exp_p[$];
  logic exp_l[$];
  int   obs_p[$];
  logic obs_l[$];

  period_meter #(
    .CNT_W         (CNT_W),
    .EXPECTED      (EXP),
    .TOL           (TOL),
    .LOCK_COUNT    (LOCKN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .sig_in      (sig),
`ifdef PERIOD_METER_MINMAX_EN
    .stats_clr   (stats_clr),
    .period_min  (period_min),
    .period_max  (period_max),
`endif
    .period_out  (period_out),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is logged, so a strobe that is stretched
  // or repeated shows up as extra entries.
  always @(negedge clk) begin
    if (rst_n && period_valid) begin
      obs_p.push_back(int'(period_out));
      obs_l.push_back(locked);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, limit 600000", $time);
    $fatal(1);
  end

  // Reference model working on gaps between rises: a gap longer than the
  // timeout discards the period and the lock run. Any other gap is reported
  // as-is, and the lock run grows or resets from its range check.
  function automatic void build_expected();
    int lc;
    lc = 0;
    exp_p.delete();
    exp_l.delete();
    foreach (gaps_q[i]) begin
      if (gaps_q[i] > TO) begin
        lc = 0;
      end else begin
        if (gaps_q[i] >= EXP - TOL && gaps_q[i] <= EXP + TOL)
          lc = (lc < LOCKN) ? lc + 1 : LOCKN;
        else
          lc = 0;
        exp_p.push_back(gaps_q[i]);
        exp_l.push_back(lc == LOCKN);
      end
    end
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_p.delete();
    obs_l.delete();
  endtask

  // One initial rise, then one more rise after each gap in gaps_q.
  task automatic drive_train();
    @(posedge clk);
    #1 sig = 1'b1;
    foreach (gaps_q[i]) begin
      repeat (gaps_q[i] / 2) @(posedge clk);
      #1 sig = 1'b0;
      repeat (gaps_q[i] - gaps_q[i] / 2) @(posedge clk);
      #1 sig = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 sig = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sig = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (period_out !== 8'd0)  begin errors++; $display("FAIL rst_period: got %0d want 0", period_out); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", period_valid); end
    checks++; if (locked !== 1'b0)       begin errors++; $display("FAIL rst_locked: got %0b want 0", locked); end
    checks++; if (timeout !== 1'b0)      begin errors++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
  endtask

  task automatic test_square();
    sig = 1'b0;
    do_reset();
    gaps_q = '{20, 20, 20, 20};
    drive_train();
    exp_p = '{20, 20, 20, 20};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs_p.size() !== exp_p.size()) begin
      errors++; $display("FAIL square_count: got %0d pulses want %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
      checks++;
      if (obs_p[i] !== exp_p[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL square_pulse%0d: got period %0d locked %0b want period %0d locked %0b",
                 i, obs_p[i], obs_l[i], exp_p[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_relock();
    sig = 1'b0;
    do_reset();
    gaps_q = '{20, 20, 20, 20, 23, 20, 20, 20};
    drive_train();
    build_expected();
    checks++;
    if (obs_p.size() !== exp_p.size()) begin
      errors++; $display("FAIL relock_count: got %0d pulses want %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
      checks++;
      if (obs_p[i] !== exp_p[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL relock_pulse%0d: got period %0d locked %0b want period %0d locked %0b",
                 i, obs_p[i], obs_l[i], exp_p[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_boundary();
    sig = 1'b0;
    do_reset();
    // 40 equals the timeout and is still reported; 41 is lost to timeout.
    gaps_q = '{20, 20, 20, 40, 20, 41, 20, 20, 20, 18};
    drive_train();
    build_expected();
    checks++;
    if (obs_p.size() !== exp_p.size()) begin
      errors++; $display("FAIL bound_count: got %0d pulses want %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
      checks++;
      if (obs_p[i] !== exp_p[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bound_pulse%0d: got period %0d locked %0b want period %0d locked %0b",
                 i, obs_p[i], obs_l[i], exp_p[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    sig = 1'b0;
    do_reset();
    gaps_q = '{20, 20, 20};
    drive_train();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL to_prelock: got %0b want 1", locked); end
    waited = 0;
    while (timeout !== 1'b1 && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %0b want 1 after %0d cycles", timeout, waited); end
    checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL to_unlock: got %0b want 0", locked); end
    obs_p.delete();
    obs_l.delete();
    gaps_q = '{20};
    drive_train();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b want 0", timeout); end
    checks++;
    if (obs_p.size() !== 1) begin
      errors++; $display("FAIL to_resume_count: got %0d pulses want 1", obs_p.size());
    end else if (obs_p[0] !== 20 || obs_l[0] !== 1'b0) begin
      errors++; $display("FAIL to_resume: got period %0d locked %0b want period 20 locked 0", obs_p[0], obs_l[0]);
    end
  endtask

  task automatic test_high_at_reset();
    int waited;
    sig = 1'b1;
    do_reset();
    waited = 0;
    while (timeout !== 1'b1 && waited < 70) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (timeout !== 1'b1 || waited < 36 || waited > 46) begin
      errors++; $display("FAIL hi_timeout: got timeout %0b after %0d cycles want 1 after 36..46", timeout, waited);
    end
    checks++; if (obs_p.size() !== 0) begin errors++; $display("FAIL hi_noedge: got %0d pulses want 0", obs_p.size()); end
    @(posedge clk);
    #1 sig = 1'b0;
    repeat (4) @(posedge clk);
    gaps_q = '{20};
    drive_train();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL hi_clear: got %0b want 0", timeout); end
    checks++;
    if (obs_p.size() !== 1) begin
      errors++; $display("FAIL hi_resume_count: got %0d pulses want 1", obs_p.size());
    end else if (obs_p[0] !== 20) begin
      errors++; $display("FAIL hi_resume: got period %0d want 20", obs_p[0]);
    end
  endtask

  task automatic test_mid_reset();
    sig = 1'b0;
    do_reset();
    gaps_q = '{20, 20, 20};
    drive_train();
    checks++; if (locked !== 1'b1)      begin errors++; $display("FAIL mr_prelock: got %0b want 1", locked); end
    checks++; if (period_out !== 8'd20) begin errors++; $display("FAIL mr_preperiod: got %0d want 20", period_out); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (period_out !== 8'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mr_zero: got period %0d valid %0b locked %0b timeout %0b want all 0",
               period_out, period_valid, locked, timeout);
    end
    obs_p.delete();
    obs_l.delete();
    gaps_q = '{20};
    drive_train();
    checks++;
    if (obs_p.size() !== 1) begin
      errors++; $display("FAIL mr_first_rise: got %0d pulses want 1", obs_p.size());
    end else if (obs_p[0] !== 20) begin
      errors++; $display("FAIL mr_period: got %0d want 20", obs_p[0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      sig = 1'b0;
      do_reset();
      gaps_q.delete();
      for (int k = 0; k < 14; k++) begin
        if ($urandom_range(0, 9) < 7) gaps_q.push_back(int'($urandom_range(19, 21)));
        else                          gaps_q.push_back(int'($urandom_range(5, 48)));
      end
      drive_train();
      build_expected();
      checks++;
      if (obs_p.size() !== exp_p.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d pulses want %0d", r, obs_p.size(), exp_p.size());
      end
      for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
        checks++;
        if (obs_p[i] !== exp_p[i] || obs_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL rand%0d_pulse%0d: got period %0d locked %0b want period %0d locked %0b",
                   r, i, obs_p[i], obs_l[i], exp_p[i], exp_l[i]);
        end
      end
    end
  endtask

`ifdef PERIOD_METER_MINMAX_EN
  task automatic test_minmax();
    sig = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (period_min !== 8'd255 || period_max !== 8'd0) begin
      errors++; $display("FAIL mm_reset: got min %0d max %0d want 255 0", period_min, period_max);
    end
    gaps_q = '{19, 21, 20};
    drive_train();
    checks++;
    if (period_min !== 8'd19 || period_max !== 8'd21) begin
      errors++; $display("FAIL mm_stats: got min %0d max %0d want 19 21", period_min, period_max);
    end
    @(posedge clk);
    #1 stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (period_min !== 8'd255 || period_max !== 8'd0) begin
      errors++; $display("FAIL mm_clear: got min %0d max %0d want 255 0", period_min, period_max);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_relock();
    test_boundary();
    test_timeout();
    test_high_at_reset();
    test_mid_reset();
    test_random();
`ifdef PERIOD_METER_MINMAX_EN
    test_minmax();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
